// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory-stage load/store unit driving a variable-latency data bus,
// with byte-enabled stores, sign/zero-extended loads and misaligned/illegal access flagging.
module mem_stage_lsu #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  MemReadM_i,
    input  logic                  MemWriteM_i,
    input  logic [2:0]            funct3M_i,
    input  logic [ADDR_WIDTH-1:0] ALUResultM_i,
    input  logic [DATA_WIDTH-1:0] WriteDataM_i,
    output logic [DATA_WIDTH-1:0] ReadDataM_o,
    output logic                  StallM_o,
    output logic                  MisalignM_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [3:0]            mem_be_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;
    state_t r_state, w_next;
    logic                  w_start, w_store, w_legal_f3, w_misal, w_bad, w_go;
    logic [DATA_WIDTH-1:0] w_wdata, w_shift, w_load;
    logic [3:0]            w_be;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [1:0]            r_off;
    logic [2:0]            r_f3;
    logic                  r_we;
    logic [DATA_WIDTH-1:0] r_wdata, r_rdata;
    logic [3:0]            r_be;

    // A simultaneous read and write is handled as a store.
    assign w_start    = MemReadM_i | MemWriteM_i;
    assign w_store    = MemWriteM_i;
    assign w_legal_f3 = w_store ? (funct3M_i inside {3'b000, 3'b001, 3'b010})
                                : (funct3M_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    assign w_misal    = (funct3M_i[1:0] == 2'b01 && ALUResultM_i[0]) ||
                        (funct3M_i[1:0] == 2'b10 && ALUResultM_i[1:0] != 2'b00);
    assign w_bad      = w_start & (~w_legal_f3 | w_misal);
    assign w_go       = w_start & ~w_bad;

    assign w_wdata = funct3M_i[1:0] == 2'b00 ? {4{WriteDataM_i[7:0]}} :
                     funct3M_i[1:0] == 2'b01 ? {2{WriteDataM_i[15:0]}} : WriteDataM_i;
    assign w_be    = funct3M_i[1:0] == 2'b00 ? 4'b0001 << ALUResultM_i[1:0] :
                     funct3M_i[1:0] == 2'b01 ? 4'b0011 << ALUResultM_i[1:0] : 4'b1111;

    assign w_shift = mem_rdata_i >> {r_off, 3'b000};
    assign w_load  = r_f3 == 3'b000 ? {{24{w_shift[7]}}, w_shift[7:0]} :
                     r_f3 == 3'b001 ? {{16{w_shift[15]}}, w_shift[15:0]} :
                     r_f3 == 3'b100 ? {24'b0, w_shift[7:0]} :
                     r_f3 == 3'b101 ? {16'b0, w_shift[15:0]} : w_shift;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_go ? REQ : IDLE;
            REQ:     w_next = mem_gnt_i ? (r_we ? DONE : WAIT_R) : REQ;
            WAIT_R:  w_next = mem_rvalid_i ? DONE : WAIT_R;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        mem_req_o   = r_state == REQ;
        StallM_o    = (r_state == IDLE && w_go) || r_state == REQ || r_state == WAIT_R;
        MisalignM_o = rst_ni && r_state == IDLE && w_bad;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_addr  <= '0;
            r_off   <= '0;
            r_f3    <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_be    <= '0;
            r_rdata <= '0;
        end else begin
            if (r_state == IDLE && w_go) begin
                r_addr  <= {ALUResultM_i[ADDR_WIDTH-1:2], 2'b00};
                r_off   <= ALUResultM_i[1:0];
                r_f3    <= funct3M_i;
                r_we    <= w_store;
                r_wdata <= w_wdata;
                r_be    <= w_be;
            end
            if (r_state == WAIT_R && mem_rvalid_i) r_rdata <= w_load;
        end
    end

    assign mem_we_o    = r_we;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign mem_be_o    = r_be;
    assign ReadDataM_o = r_rdata;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed and randomized load/store accesses against a byte-level reference model.
module tb_mem_stage_lsu;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        MemReadM_i, MemWriteM_i;
    logic [2:0]  funct3M_i;
    logic [31:0] ALUResultM_i, WriteDataM_i;
    logic [31:0] ReadDataM_o;
    logic        StallM_o, MisalignM_o, mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_rd = 32'h0;

    mem_stage_lsu dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .MemReadM_i(MemReadM_i), .MemWriteM_i(MemWriteM_i), .funct3M_i(funct3M_i),
        .ALUResultM_i(ALUResultM_i), .WriteDataM_i(WriteDataM_i),
        .ReadDataM_o(ReadDataM_o), .StallM_o(StallM_o), .MisalignM_o(MisalignM_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
        int          nb = 1 << f3[1:0];
        logic [63:0] v, mask;
        v    = {32'b0, w} >> (8 * off);
        mask = (64'd1 << (8 * nb)) - 64'd1;
        v    = v & mask;
        if (!f3[2] && nb < 4 && v[8*nb-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [31:0] d, input int nb);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % nb) +: 8];
        return r;
    endfunction

    function automatic logic [3:0] ref_be(input int nb, input logic [1:0] off);
        int m = ((1 << nb) - 1) << off;
        return m[3:0];
    endfunction

    // One access: g = cycles without grant, rv = extra cycles before rvalid.
    task automatic do_access(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] data, input int g, input int rv, input logic [31:0] rdata);
        bit store = wr;
        int nb    = 1 << f3[1:0];
        bit legal = store ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        bit ok    = legal && (addr % nb == 0);
        @(negedge clk_i);
        MemReadM_i = rd; MemWriteM_i = wr; funct3M_i = f3; ALUResultM_i = addr; WriteDataM_i = data;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        #1;
        if (!ok) begin
            chk("bad_misalign", 32'(MisalignM_o), 32'd1);
            chk("bad_stall", 32'(StallM_o), 32'd0);
            chk("bad_req", 32'(mem_req_o), 32'd0);
            @(negedge clk_i);
            MemReadM_i = 1'b0; MemWriteM_i = 1'b0;
            #1;
            chk("bad_misalign_clear", 32'(MisalignM_o), 32'd0);
            chk("bad_req_after", 32'(mem_req_o), 32'd0);
            chk("bad_rdata_held", ReadDataM_o, exp_rd);
            return;
        end
        chk("idle_stall", 32'(StallM_o), 32'd1);
        chk("idle_misalign", 32'(MisalignM_o), 32'd0);
        chk("idle_req", 32'(mem_req_o), 32'd0);
        for (int k = 0; k <= g; k++) begin
            @(negedge clk_i);
            mem_gnt_i = (k == g);
            mem_rvalid_i = (k != g) ? 1'($urandom % 2) : 1'b0;
            mem_rdata_i = $urandom;
            #1;
            chk("req_req", 32'(mem_req_o), 32'd1);
            chk("req_we", 32'(mem_we_o), 32'(store));
            chk("req_addr", mem_addr_o, addr & ~32'd3);
            chk("req_stall", 32'(StallM_o), 32'd1);
            if (store) begin
                chk("req_wdata", mem_wdata_o, ref_wdata(data, nb));
                chk("req_be", 32'(mem_be_o), 32'(ref_be(nb, addr[1:0])));
            end
        end
        if (!store) begin
            for (int k = 0; k <= rv; k++) begin
                @(negedge clk_i);
                mem_gnt_i = 1'b0;
                mem_rvalid_i = (k == rv);
                mem_rdata_i = (k == rv) ? rdata : $urandom;
                #1;
                chk("wait_req", 32'(mem_req_o), 32'd0);
                chk("wait_stall", 32'(StallM_o), 32'd1);
                chk("wait_rdata_old", ReadDataM_o, exp_rd);
            end
            exp_rd = ref_load(f3, addr[1:0], rdata);
        end
        @(negedge clk_i);
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        #1;
        chk("done_stall", 32'(StallM_o), 32'd0);
        chk("done_req", 32'(mem_req_o), 32'd0);
        chk("done_rdata", ReadDataM_o, exp_rd);
    endtask

    initial begin
        rst_ni = 1'b0;
        MemReadM_i = 1'b0; MemWriteM_i = 1'b0; funct3M_i = 3'd0; ALUResultM_i = 32'd0; WriteDataM_i = 32'd0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'd0;
        #1;
        chk("rst_req", 32'(mem_req_o), 32'd0);
        chk("rst_we", 32'(mem_we_o), 32'd0);
        chk("rst_addr", mem_addr_o, 32'd0);
        chk("rst_wdata", mem_wdata_o, 32'd0);
        chk("rst_be", 32'(mem_be_o), 32'd0);
        chk("rst_rdata", ReadDataM_o, 32'd0);
        chk("rst_misalign", 32'(MisalignM_o), 32'd0);
        chk("rst_stall", 32'(StallM_o), 32'd0);
        @(negedge clk_i); @(negedge clk_i);
        rst_ni = 1'b1;

        do_access(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0);
        do_access(1'b0, 1'b1, 3'b000, 32'h203, 32'h000000A5, 0, 0, 32'h0);
        do_access(1'b1, 1'b0, 3'b000, 32'h001, 32'h0, 0, 0, 32'h00008000);
        chk("lb_value", ReadDataM_o, 32'hFFFFFF80);
        do_access(1'b1, 1'b0, 3'b100, 32'h001, 32'h0, 0, 0, 32'h00008000);
        chk("lbu_value", ReadDataM_o, 32'h00000080);
        do_access(1'b1, 1'b0, 3'b101, 32'h002, 32'h0, 0, 0, 32'hBEEF0000);
        chk("lhu_value", ReadDataM_o, 32'h0000BEEF);
        do_access(1'b1, 1'b0, 3'b010, 32'h344, 32'h0, 3, 1, 32'h13579BDF);
        do_access(1'b1, 1'b0, 3'b001, 32'h101, 32'h0, 0, 0, 32'h0);
        do_access(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 0, 0, 32'h0);
        do_access(1'b0, 1'b1, 3'b100, 32'h100, 32'h12345678, 0, 0, 32'h0);
        do_access(1'b1, 1'b1, 3'b001, 32'h206, 32'hCAFEF00D, 1, 0, 32'h0);
        do_access(1'b1, 1'b0, 3'b001, 32'h002, 32'h0, 0, 0, 32'h8001FFFF);
        chk("lh_value", ReadDataM_o, 32'hFFFF8001);

        for (int n = 0; n < 40; n++) begin
            int          sel = $urandom_range(0, 2);
            logic [2:0]  f3  = 3'($urandom_range(0, 7));
            logic [31:0] a   = $urandom & 32'hFFFF;
            if ($urandom % 2 == 1) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
            do_access(sel != 1, sel != 0, f3, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 2), $urandom);
        end

        // Reset while waiting for read data; the late rvalid must be ignored.
        @(negedge clk_i);
        MemReadM_i = 1'b1; MemWriteM_i = 1'b0; funct3M_i = 3'b010; ALUResultM_i = 32'h40;
        @(negedge clk_i);
        mem_gnt_i = 1'b1;
        @(negedge clk_i);
        mem_gnt_i = 1'b0; MemReadM_i = 1'b0;
        #1;
        chk("wr_stall_before_rst", 32'(StallM_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("midrst_req", 32'(mem_req_o), 32'd0);
        chk("midrst_stall", 32'(StallM_o), 32'd0);
        chk("midrst_rdata", ReadDataM_o, 32'd0);
        chk("midrst_addr", mem_addr_o, 32'd0);
        exp_rd = 32'h0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h12345678;
        @(negedge clk_i);
        mem_rvalid_i = 1'b0;
        #1;
        chk("late_rvalid_rdata", ReadDataM_o, 32'd0);
        chk("late_rvalid_stall", 32'(StallM_o), 32'd0);
        chk("late_rvalid_req", 32'(mem_req_o), 32'd0);
        do_access(1'b1, 1'b0, 3'b000, 32'h7, 32'h0, 0, 0, 32'h7F000000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-stage load/store unit. It consumes the execute-to-memory register outputs (ALUResultM, WriteDataM, MemWriteM, plus MemReadM and funct3M) and acts as the initiator toward a variable-latency data-memory bus.
- It performs byte-enabled stores and sign/zero-extended loads.
- It stalls the pipeline with StallM_o until each access completes, and flags misaligned or illegal accesses instead of issuing them.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, data width; fixed at 32, four byte lanes.

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- MemReadM_i  in  1  load in memory stage
- MemWriteM_i  in  1  store in memory stage
- funct3M_i  in  3  access size/sign (RV32I load/store funct3)
- ALUResultM_i  in  ADDR_WIDTH  byte address
- WriteDataM_i  in  DATA_WIDTH  store data (rs2)
- ReadDataM_o  out  DATA_WIDTH  formatted load result
- StallM_o  out  1  hold IF..MEM stages
- MisalignM_o  out  1  one-cycle misaligned/illegal flag
- mem_req_o  out  1  bus request
- mem_we_o  out  1  1 = write
- mem_addr_o  out  ADDR_WIDTH  word-aligned address, bits [1:0] = 0
- mem_wdata_o  out  DATA_WIDTH  lane-replicated write data
- mem_be_o  out  4  byte enables
- mem_gnt_i  in  1  request accepted
- mem_rvalid_i  in  1  read data valid
- mem_rdata_i  in  DATA_WIDTH  read word

Behaviour:
- Reset (asynchronous, rst_ni = 0):
  - State goes to IDLE.
  - mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, ReadDataM_o and MisalignM_o are all 0.
  - StallM_o follows the combinational rule below, so it is 0 in IDLE with no access.
  - Reset mid-access abandons the access and drops mem_req_o immediately. A late mem_rvalid_i is ignored.
- Access start: MemReadM_i | MemWriteM_i. If both are high, treat the access as a store.
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other funct3 is illegal.
- Misaligned access: halfword with addr[0] = 1, or word with addr[1:0] != 0.
- Misaligned or illegal access: no bus request is issued, and the store is suppressed. MisalignM_o = 1 for exactly that cycle. StallM_o = 0. ReadDataM_o is unchanged.
- State machine (IDLE, REQ, WAIT_R, DONE):
  - IDLE: on a legal access, latch address, data, size and type, then go to REQ next cycle.
  - REQ: mem_req_o = 1, with mem_we_o, mem_addr_o, mem_wdata_o and mem_be_o stable until mem_gnt_i.
    - Store, gnt = 1: go to DONE.
    - Load, gnt = 1: go to WAIT_R.
    - gnt = 0: stay in REQ.
  - WAIT_R: wait for mem_rvalid_i. On rvalid, capture the formatted result into ReadDataM_o and go to DONE. mem_req_o = 0.
  - DONE: StallM_o = 0, and the pipeline advances at the end of this cycle. Unconditionally return to IDLE.
- StallM_o is combinational. It is 1 when:
  - in IDLE with a legal access present, or
  - in REQ, or
  - in WAIT_R.
- Minimum latency: a store costs 2 stall cycles with gnt in the first REQ cycle. A load costs 3 stall cycles with rvalid in the cycle after gnt.
- Store formatting (o = addr[1:0]):
  - SB: wdata = {4{b[7:0]}}, be = 0001 << o.
  - SH: wdata = {2{h[15:0]}}, be = 0011 << o.
  - SW: wdata = data, be = 1111.
- Load formatting: shift rdata right by 8*o, then sign-extend (LB/LH) or zero-extend (LBU/LHU). LW passes the word through.
- ReadDataM_o holds its last value between loads; stores do not modify it.
- mem_rvalid_i outside WAIT_R is ignored. rvalid is never expected in the same cycle as gnt.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, gnt on first REQ cycle -> mem_addr_o = 0x100, be = 1111, wdata = 0xDEADBEEF, we = 1; StallM_o high for 2 cycles, then DONE.
- SB addr 0x203, data 0x000000A5 -> mem_addr_o = 0x200, be = 1000, wdata = 0xA5A5A5A5.
- LB addr 0x001, rdata 0x00008000 one cycle after gnt -> ReadDataM_o = 0xFFFFFF80. Same access as LBU -> 0x00000080. LHU addr 0x002, rdata 0xBEEF0000 -> 0x0000BEEF.
- LW with gnt delayed 3 cycles and rvalid 2 cycles after gnt -> mem_req_o and signals stable throughout REQ; StallM_o held for 1 + 3 + 1 + 2 cycles; DONE the cycle after rvalid.
- LH addr 0x101, and also funct3 = 011 -> MisalignM_o pulses once each, mem_req_o never asserted, StallM_o = 0, ReadDataM_o unchanged.
- rst_ni low while in WAIT_R, then rvalid arrives after release -> state IDLE, mem_req_o = 0, ReadDataM_o = 0, rvalid ignored.
